// File: rtl/mul8_pkg.sv
// Shared definitions for the sequential 8x8 multiplier controller.
package mul8_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int STEP_W = 2;

    // Left shift applied to each nibble partial product, indexed by step
    localparam logic [3:0] SHIFT_S0 = 4'd0;
    localparam logic [3:0] SHIFT_S1 = 4'd4;
    localparam logic [3:0] SHIFT_S2 = 4'd4;
    localparam logic [3:0] SHIFT_S3 = 4'd8;

    function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
        logic [3:0] sh;
        case (step)
            2'd0:    sh = SHIFT_S0;
            2'd1:    sh = SHIFT_S1;
            2'd2:    sh = SHIFT_S2;
            default: sh = SHIFT_S3;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul8_seq_ctrl_if.sv
// Operand/result handshake bundle between the pin decode, the controller
// and the output mux.
interface mul8_seq_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       a;
    logic [7:0]       b;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      product;
    logic             busy;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy, op_count
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy, op_count
    );
endinterface

// File: rtl/mul8_seq_ctrl_mul4x4_array.sv
// Combinational unsigned 4x4 -> 8 array multiplier: AND-gated rows summed
// by ripple chains of full adders.
module mul4x4_array (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    output logic [7:0] o_p
);

    logic [7:0] w_sum;
    logic [7:0] w_row;
    logic       w_c;
    logic       w_s_bit;

    // Accumulate each shifted AND row into the running sum, bit by bit
    always_comb begin
        w_sum   = {4'b0000, i_a & {4{i_b[0]}}};
        w_row   = 8'h00;
        w_c     = 1'b0;
        w_s_bit = 1'b0;
        for (int row = 1; row < 4; row++) begin
            w_row = {4'b0000, i_a & {4{i_b[row]}}} << row;
            w_c   = 1'b0;
            for (int k = 0; k < 8; k++) begin
                w_s_bit  = w_sum[k] ^ w_row[k] ^ w_c;
                w_c      = (w_sum[k] & w_row[k]) | (w_c & (w_sum[k] ^ w_row[k]));
                w_sum[k] = w_s_bit;
            end
        end
    end

    assign o_p = w_sum;

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 -> 16 multiplier: one shared 4x4 array, four accumulation
// steps per operand pair, result held until the consumer takes it.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | in_ready high; in_valid captures a/b and starts a product
// MUL     | busy high; one nibble partial product accumulated per edge
// DONE    | out_valid high; product held until out_ready
module mul8_seq_ctrl
    import mul8_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    mul8_seq_ctrl_if.slave bus
);

    state_e              r_state;
    state_e              w_next;
    logic [STEP_W-1:0]   r_step;
    logic [7:0]          r_a;
    logic [7:0]          r_b;
    logic [15:0]         r_acc;
    logic [CNT_W-1:0]    r_count;

    logic                w_accept;
    logic                w_deliver;
    logic                w_in_ready;
    logic                w_busy;
    logic                w_out_valid;
    logic [3:0]          w_nib_a;
    logic [3:0]          w_nib_b;
    logic [7:0]          w_pp;
    logic [15:0]         w_pp_shifted;

    // Step bit 0 picks the multiplicand half, bit 1 the multiplier half,
    // which reproduces the lo*lo, hi*lo, lo*hi, hi*hi schedule.
    assign w_nib_a = r_step[0] ? r_a[7:4] : r_a[3:0];
    assign w_nib_b = r_step[1] ? r_b[7:4] : r_b[3:0];

    mul4x4_array u_mul4x4 (
        .i_a (w_nib_a),
        .i_b (w_nib_b),
        .o_p (w_pp)
    );

    assign w_pp_shifted = {8'h00, w_pp} << step_shift(r_step);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_busy      = 1'b0;
        w_out_valid = 1'b0;
        w_accept    = 1'b0;
        w_deliver   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_accept = 1'b1;
                    w_next   = ST_MUL;
                end
            end
            ST_MUL: begin
                w_busy = 1'b1;
                if (r_step == STEP_W'(3)) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_deliver = 1'b1;
                    w_next    = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Operand capture, step counting and accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= 8'h00;
            r_b    <= 8'h00;
            r_step <= '0;
            r_acc  <= 16'h0000;
        end else if (w_accept) begin
            r_a    <= bus.a;
            r_b    <= bus.b;
            r_step <= '0;
            r_acc  <= 16'h0000;
        end else if (r_state == ST_MUL) begin
            r_acc  <= r_acc + w_pp_shifted;
            r_step <= r_step + STEP_W'(1);
        end
    end

    // Delivered-result counter, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_deliver) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.busy      = w_busy;
    assign bus.out_valid = w_out_valid;
    assign bus.product   = r_acc;
    assign bus.op_count  = r_count;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Randomised self-checking bench for mul8_seq_ctrl; reference model is the
// plain arithmetic product and a delivered-result count.
module tb_mul8_seq_ctrl;

    localparam int CNT_W = 8;
    localparam int N_B2B = 257;

    logic clk;
    logic rst_n;

    mul8_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

    mul8_seq_ctrl #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks;
    int n_fail;
    int exp_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] cnt_model();
        return 32'(exp_cnt % (1 << CNT_W));
    endfunction

    // One full transaction from IDLE; hold = cycles of out_ready low in DONE,
    // scramble = drive random a/b every cycle while the product is computed.
    task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                         input int hold, input bit scramble);
        logic [15:0] exp_p;
        int          n;
        exp_p = 16'(ta) * 16'(tb_v);
        chk("idle_in_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.a         = ta;
        bus.b         = tb_v;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            chk("mul_busy", 32'(bus.busy), 32'd1);
            if (scramble) begin
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'd4);
        for (int h = 0; h < hold; h++) begin
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_product", 32'(bus.product), 32'(exp_p));
            bus.in_valid = 1'b1;
            bus.a        = 8'($urandom);
            bus.b        = 8'($urandom);
            @(negedge clk);
        end
        chk("product", 32'(bus.product), 32'(exp_p));
        chk("done_busy", 32'(bus.busy), 32'd0);
        bus.out_ready = 1'b1;
        @(negedge clk);
        exp_cnt++;
        bus.out_ready = 1'b0;
        chk("release_out_valid", 32'(bus.out_valid), 32'd0);
        chk("release_no_accept", 32'(bus.in_ready), 32'd1);
        chk("release_product_kept", 32'(bus.product), 32'(exp_p));
        chk("op_count", 32'(bus.op_count), cnt_model());
        bus.in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_product", 32'(bus.product), 32'd0);
        chk("rst_op_count", 32'(bus.op_count), 32'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] q[$];
        logic [7:0]  ra;
        logic [7:0]  rb;
        int          acc_cnt;
        int          done_cnt;
        int          last_acc;

        n_checks = 0;
        n_fail   = 0;
        exp_cnt  = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a = 8'h00;
        bus.b = 8'h00;
        rst_n = 1'b1;
        @(negedge clk);
        apply_reset();

        // Abort mid-computation: reset at step 2 of 0x12*0x34
        bus.in_valid = 1'b1;
        bus.a = 8'h12;
        bus.b = 8'h34;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", 32'(bus.busy), 32'd1);
        #2;
        apply_reset();

        do_op(8'h03, 8'h05, 0, 1'b0);
        do_op(8'h12, 8'h34, 0, 1'b0);
        do_op(8'hFF, 8'hFF, 0, 1'b0);
        do_op(8'h00, 8'hB7, 0, 1'b0);
        do_op(8'hA5, 8'h5A, 10, 1'b0);
        do_op(8'hC3, 8'h7E, 0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            do_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 4)), 1'($urandom));
        end

        // Back-to-back run with in_valid/out_ready tied high
        apply_reset();
        acc_cnt  = 0;
        done_cnt = 0;
        last_acc = 0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 2000 && done_cnt < N_B2B; cyc++) begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    chk("b2b_unexpected_result", 32'(bus.product), 32'hFFFF_FFFF);
                end else begin
                    chk("b2b_product", 32'(bus.product), 32'(q.pop_front()));
                end
                done_cnt++;
            end
            if (bus.in_ready && acc_cnt < N_B2B) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                bus.a = ra;
                bus.b = rb;
                q.push_back(16'(ra) * 16'(rb));
                if (acc_cnt > 0) begin
                    chk("b2b_period", 32'(cyc - last_acc), 32'd6);
                end
                last_acc = cyc;
                acc_cnt++;
            end
            if (done_cnt >= N_B2B) begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        exp_cnt = done_cnt;
        chk("b2b_done", 32'(done_cnt), 32'(N_B2B));
        chk("b2b_op_count_wrap", 32'(bus.op_count), cnt_model());
        chk("b2b_op_count_one", 32'(bus.op_count), 32'd1);
        chk("b2b_idle", 32'(bus.in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
